// File: rtl/ppl_exit.sv
// ppl_exit: ray-march pipeline exit stage with feedback register, pixel write FIFO and frame-done pulse
`ifndef DISP_RAM_ADDR_RADIX
`define DISP_RAM_ADDR_RADIX 17
`endif
`ifndef EOF_ADDR
`define EOF_ADDR 76799
`endif
module ppl_exit #(
  parameter int ADDR_W = `DISP_RAM_ADDR_RADIX,
  parameter int COLOR_W = 12,
  parameter int MAX_ITER = 64,
  parameter int FIFO_DEPTH = 8,
  parameter logic [COLOR_W-1:0] SKY_COLOR = 12'h8CF
) (
  input  logic clk_ppl,
  input  logic rst,
  input  logic in_valid,
  input  logic [ADDR_W-1:0] in_pixel_addr,
  input  logic [31:0] in_color_acc,
  input  logic [1:0] in_dir,
  input  logic [95:0] in_block_p,
  input  logic [95:0] in_hit_p,
  input  logic [95:0] in_start_p,
  input  logic [95:0] in_end_p,
  input  logic in_is_behind,
  input  logic [7:0] in_iter,
  input  logic in_hit,
  input  logic in_out_of_world,
  output logic out_valid,
  output logic next_pixel_pplout,
  output logic [ADDR_W-1:0] pixel_addr_pplout,
  output logic [31:0] to_color_acc_pplout,
  output logic [1:0] to_dir_pplout,
  output logic [95:0] to_block_p_pplout,
  output logic [95:0] to_hit_p_pplout,
  output logic [95:0] start_p_pplout,
  output logic [95:0] end_p_pplout,
  output logic to_is_behind_pplout,
  output logic [7:0] to_iter_pplout,
  output logic wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  input  logic wr_ready,
  output logic buf_full,
  output logic frame_done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W + COLOR_W;
  localparam logic [7:0] ITER_LIM = 8'(MAX_ITER - 1);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] EOF_A = ADDR_W'(`EOF_ADDR);
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_cnt;
  logic w_term, w_push, w_pop;
  logic [COLOR_W-1:0] w_color;
  logic [EW-1:0] w_head;
  logic [7:0] w_iter_next;
  assign w_term = in_valid & (in_hit | in_out_of_world | in_is_behind | (in_iter >= ITER_LIM));
  assign buf_full = r_cnt == FULL_CNT;
  assign w_push = w_term & ~buf_full;
  assign wr_en = r_cnt != '0;
  assign w_pop = wr_en & wr_ready;
  assign w_color = in_hit ? in_color_acc[COLOR_W-1:0] : SKY_COLOR;
  assign w_head = wr_en ? r_mem[r_rp] : '0;
  assign {wr_addr, wr_data} = w_head;
  assign w_iter_next = w_term ? in_iter : (in_iter == 8'hFF ? in_iter : in_iter + 8'd1);
  // Feedback register: continuing rays advance their iteration, terminating or retried rays recirculate unchanged
  always_ff @(posedge clk_ppl or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      next_pixel_pplout <= 1'b0;
      pixel_addr_pplout <= '0;
      to_color_acc_pplout <= '0;
      to_dir_pplout <= '0;
      to_block_p_pplout <= '0;
      to_hit_p_pplout <= '0;
      start_p_pplout <= '0;
      end_p_pplout <= '0;
      to_is_behind_pplout <= 1'b0;
      to_iter_pplout <= '0;
    end else begin
      out_valid <= in_valid;
      next_pixel_pplout <= w_push;
      pixel_addr_pplout <= in_pixel_addr;
      if (in_valid) begin
        to_color_acc_pplout <= in_color_acc;
        to_dir_pplout <= in_dir;
        to_block_p_pplout <= in_block_p;
        to_hit_p_pplout <= in_hit_p;
        start_p_pplout <= in_start_p;
        end_p_pplout <= in_end_p;
        to_is_behind_pplout <= in_is_behind;
        to_iter_pplout <= w_iter_next;
      end
    end
  end
  // Write buffer storage; validity is tracked by the pointers, so contents need no reset
  always_ff @(posedge clk_ppl) begin
    if (w_push) r_mem[r_wp] <= {in_pixel_addr, w_color};
  end
  // Write buffer pointers and occupancy; reset discards any pending pixels
  always_ff @(posedge clk_ppl or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp <= w_pop ? r_rp + 1'b1 : r_rp;
      r_cnt <= (w_push & ~w_pop) ? r_cnt + 1'b1 : (~w_push & w_pop) ? r_cnt - 1'b1 : r_cnt;
    end
  end
  // Frame-done pulses once after the last pixel of the frame leaves the buffer
  always_ff @(posedge clk_ppl or posedge rst) begin
    if (rst) frame_done <= 1'b0;
    else frame_done <= w_pop & (wr_addr == EOF_A);
  end
endmodule

// File: doc/ppl_exit.md
Name: ppl_exit

Overview:
- Tail end of the ray-march pipeline: the counterpart of the pipeline entry stage.
- Takes each ray bundle from the last march stage and decides one of two outcomes:
  - the ray terminates: its pixel colour goes to the display RAM write port, and the entry stage is told to inject a new pixel (next_pixel_pplout=1);
  - the ray continues: the bundle is fed back to the entry as *_pplout signals.
- Owns the display-RAM write buffer and the frame-done indication.

Parameters:
- ADDR_W, `DISP_RAM_ADDR_RADIX, pixel address width.
- COLOR_W, 12, display RAM data width.
- MAX_ITER, 64, march iterations before forced termination.
- FIFO_DEPTH, 8, pixel write buffer entries (power of 2).
- SKY_COLOR, 12'h8CF, colour written for rays that miss.

Ports:
- clk_ppl in 1: pipeline clock.
- rst in 1: reset.
- in_valid in 1: ray bundle present from last stage.
- in_pixel_addr in ADDR_W: ray's pixel address.
- in_color_acc in 32: accumulated colour.
- in_dir in 2: last step direction.
- in_block_p in 96: {z,y,x} block position.
- in_hit_p in 96: {z,y,x} hit point.
- in_start_p in 96: {z,y,x} segment start.
- in_end_p in 96: {z,y,x} segment end.
- in_is_behind in 1: ray behind camera.
- in_iter in 8: iteration count carried with ray.
- in_hit in 1: opaque block hit this pass.
- in_out_of_world in 1: ray left world bounds.
- out_valid out 1: feedback bundle valid.
- next_pixel_pplout out 1: entry must inject new pixel.
- pixel_addr_pplout out ADDR_W: address of the ray just handled.
- to_color_acc_pplout out 32: fed-back colour.
- to_dir_pplout out 2: fed-back direction.
- to_block_p_pplout out 96: fed-back block position.
- to_hit_p_pplout out 96: fed-back hit point.
- start_p_pplout out 96: fed-back segment start.
- end_p_pplout out 96: fed-back segment end.
- to_is_behind_pplout out 1: fed-back behind flag.
- to_iter_pplout out 8: fed-back iteration count.
- wr_en out 1: display RAM write valid.
- wr_addr out ADDR_W: write address.
- wr_data out COLOR_W: write colour.
- wr_ready in 1: RAM accepts write.
- buf_full out 1: write FIFO full.
- frame_done out 1: one-cycle pulse when the EOF pixel is written.

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk_ppl. All outputs go to 0, the FIFO empties, and the count is 0.
- term = in_valid & (in_hit | in_out_of_world | in_is_behind | in_iter >= MAX_ITER-1).
- Feedback register: all *_pplout outputs and out_valid are registered, with 1-cycle latency from in_*.
  - out_valid <= in_valid.
  - pixel_addr_pplout <= in_pixel_addr, always.
- Case !in_valid: next_pixel_pplout <= 0. The other registers hold their values.
- Case in_valid & !term (continue): next_pixel_pplout <= 0. All fields pass through, and to_iter_pplout <= in_iter+1 (saturating at 255).
- Case term & !buf_full (accept): next_pixel_pplout <= 1.
  - Push {in_pixel_addr, colour} into the FIFO.
  - colour = in_hit ? in_color_acc[COLOR_W-1:0] : SKY_COLOR. Behind or miss uses SKY_COLOR.
  - Fields pass through unchanged; entry ignores them when next_pixel=1.
- Case term & buf_full (retry): next_pixel_pplout <= 0 and there is no push.
  - The bundle is recirculated unchanged, to_iter_pplout <= in_iter (not incremented).
  - The ray re-terminates on its next pass. No pixel is lost and there is no backpressure into the pipeline.
- FIFO: show-ahead; wr_en = !empty; wr_addr/wr_data = head entry.
  - Pop when wr_en & wr_ready. wr_addr/wr_data stay stable while wr_en & !wr_ready.
  - buf_full = (count == FIFO_DEPTH). Push is blocked when full, even if a pop happens the same cycle.
  - Push and pop in the same cycle when not full: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- frame_done: registered pulse the cycle after the pop of an entry whose address == `EOF_ADDR.
- Reset mid-frame: FIFO contents are discarded. No write is issued after rst rises.

Test Plan:
- Reset: assert rst with in_valid=1 → all outputs 0 and buf_full=0; one cycle after release with in_valid=0, out_valid=0.
- Continue path: in_valid=1, in_hit=0, in_iter=5, in_pixel_addr=100 → next cycle out_valid=1, next_pixel_pplout=0, to_iter_pplout=6, fields echoed, no wr_en.
- Hit termination: in_hit=1, in_color_acc=32'h0000_0ABC, addr=37, wr_ready=1 → next_pixel_pplout=1, then wr_en with wr_addr=37, wr_data=12'hABC.
- Max-iter and behind: in_iter=63 with no hit → wr_data=SKY_COLOR. in_is_behind=1 → terminates the same way.
- Backpressure: wr_ready=0 with 9 terminating rays → first 8 accepted, buf_full=1, 9th recirculated with next_pixel_pplout=0 and iter unchanged. Raise wr_ready → 8 writes drain in order.
- EOF: terminate addr=`EOF_ADDR → pixel_addr_pplout=`EOF_ADDR with next_pixel_pplout=1; single frame_done pulse after its write pops.
